// File: rtl/bcd_digit_chain.sv
// Multi-digit packed-BCD counter with programmable [MIN_BCD, MAX_BCD] range,
// up/down stepping, checked synchronous preset and a one-cycle wrap pulse.
module bcd_digit_chain #(
  parameter int                   DIGITS  = 2,
  parameter logic [4*DIGITS-1:0]  MIN_BCD = 'h00,
  parameter logic [4*DIGITS-1:0]  MAX_BCD = 'h59
) (
  input  logic                  clk_cin,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  output logic [4*DIGITS-1:0]   count,
  output logic                  cout,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  // Bad range parameters stop elaboration rather than build a counter that
  // can never reach a legal state.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $fatal(1, "bcd_digit_chain: DIGITS must be 1..8");
  end
  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    if (MIN_BCD[4*g +: 4] > 4'd9 || MAX_BCD[4*g +: 4] > 4'd9) begin : g_bad_bcd
      $fatal(1, "bcd_digit_chain: MIN_BCD/MAX_BCD must be valid BCD");
    end
  end
  if (MIN_BCD > MAX_BCD) begin : g_bad_order
    $fatal(1, "bcd_digit_chain: MIN_BCD must not exceed MAX_BCD");
  end

  function automatic logic is_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  logic [W-1:0] r_count;
  logic         r_cout;
  logic         r_load_err;

  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;
  logic         w_in_range;
  logic         w_preset_ok;

  // With every nibble <= 9, packed-BCD ordering equals unsigned ordering.
  assign w_in_range  = is_bcd(r_count) && (r_count >= MIN_BCD) && (r_count <= MAX_BCD);
  assign w_preset_ok = is_bcd(preset)  && (preset  >= MIN_BCD) && (preset  <= MAX_BCD);

  always_comb begin : p_inc
    logic c_inc;
    c_inc = 1'b1;
    w_inc = r_count;
    for (int i = 0; i < DIGITS; i++) begin
      if (c_inc) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          c_inc = 1'b0;
        end
      end
    end
  end

  always_comb begin : p_dec
    logic b_dec;
    b_dec = 1'b1;
    w_dec = r_count;
    for (int i = 0; i < DIGITS; i++) begin
      if (b_dec) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          b_dec = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_cin or posedge rst) begin
    if (rst) begin
      r_count    <= MIN_BCD;
      r_cout     <= 1'b0;
      r_load_err <= 1'b0;
    end else if (load) begin
      r_cout <= 1'b0;
      if (w_preset_ok) begin
        r_count    <= preset;
        r_load_err <= 1'b0;
      end else begin
        r_load_err <= 1'b1;
      end
    end else if (en) begin
      // An illegal count takes the wrap path, so it recovers in one step.
      if (up) begin
        if (!w_in_range || r_count == MAX_BCD) begin
          r_count <= MIN_BCD;
          r_cout  <= 1'b1;
        end else begin
          r_count <= w_inc;
          r_cout  <= 1'b0;
        end
      end else begin
        if (!w_in_range || r_count == MIN_BCD) begin
          r_count <= MAX_BCD;
          r_cout  <= 1'b1;
        end else begin
          r_count <= w_dec;
          r_cout  <= 1'b0;
        end
      end
    end else begin
      r_cout <= 1'b0;
    end
  end

  assign count    = r_count;
  assign cout     = r_cout;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_digit_chain.sv
// Directed bench for bcd_digit_chain: a 00-59 instance (a) and a 01-12 instance (b).
module tb_bcd_digit_chain;

  logic       clk_cin;
  logic       rst;
  logic       a_en, a_up, a_load;
  logic [7:0] a_preset;
  logic [7:0] a_count;
  logic       a_cout, a_load_err;
  logic       b_en, b_up, b_load;
  logic [7:0] b_preset;
  logic [7:0] b_count;
  logic       b_cout, b_load_err;

  int n_checks;
  int n_errors;

  logic [7:0] exp_q[$];
  logic       exp_c_q[$];

  bcd_digit_chain #(.DIGITS(2), .MIN_BCD(8'h00), .MAX_BCD(8'h59)) dut_a (
    .clk_cin(clk_cin), .rst(rst), .en(a_en), .up(a_up), .load(a_load),
    .preset(a_preset), .count(a_count), .cout(a_cout), .load_err(a_load_err)
  );

  bcd_digit_chain #(.DIGITS(2), .MIN_BCD(8'h01), .MAX_BCD(8'h12)) dut_b (
    .clk_cin(clk_cin), .rst(rst), .en(b_en), .up(b_up), .load(b_load),
    .preset(b_preset), .count(b_count), .cout(b_cout), .load_err(b_load_err)
  );

  // clock / reset
  initial clk_cin = 1'b0;
  always #5 clk_cin = ~clk_cin;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // One rising edge, then settle on the falling edge for sampling.
  task automatic tick();
    @(posedge clk_cin);
    @(negedge clk_cin);
  endtask

  task automatic load_a(input logic [7:0] p);
    a_load = 1'b1; a_en = 1'b0; a_preset = p;
    tick();
    a_load = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] p);
    b_load = 1'b1; b_en = 1'b0; b_preset = p;
    tick();
    b_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_preset = 8'h00;
    b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_preset = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    n_checks++; if (a_count !== 8'h00) begin n_errors++; $display("FAIL reset_count_a: got %h want 00", a_count); end
    n_checks++; if (a_cout !== 1'b0) begin n_errors++; $display("FAIL reset_cout_a: got %b want 0", a_cout); end
    n_checks++; if (a_load_err !== 1'b0) begin n_errors++; $display("FAIL reset_err_a: got %b want 0", a_load_err); end
    n_checks++; if (b_count !== 8'h01) begin n_errors++; $display("FAIL reset_count_b: got %h want 01", b_count); end
  endtask

  task automatic test_async_reset();
    load_a(8'h30);
    a_en = 1'b1; a_up = 1'b1;
    repeat (7) tick();
    n_checks++; if (a_count !== 8'h37) begin n_errors++; $display("FAIL areset_pre: got %h want 37", a_count); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (a_count !== 8'h00) begin n_errors++; $display("FAIL areset_count: got %h want 00", a_count); end
    n_checks++; if (a_cout !== 1'b0) begin n_errors++; $display("FAIL areset_cout: got %b want 0", a_cout); end
    #1 rst = 1'b0;
    tick();
    n_checks++; if (a_count !== 8'h01) begin n_errors++; $display("FAIL areset_resume1: got %h want 01", a_count); end
    tick();
    n_checks++; if (a_count !== 8'h02) begin n_errors++; $display("FAIL areset_resume2: got %h want 02", a_count); end
    a_en = 1'b0;
  endtask

  task automatic test_up_wrap();
    int v;
    logic [7:0] e;
    logic       ec;
    load_a(8'h08);
    v = 8;
    for (int i = 0; i < 53; i++) begin
      if (v == 59) begin v = 0; exp_c_q.push_back(1'b1); end
      else begin v = v + 1; exp_c_q.push_back(1'b0); end
      exp_q.push_back(to_bcd(v));
    end
    a_en = 1'b1; a_up = 1'b1;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      ec = exp_c_q.pop_front();
      n_checks++; if (a_count !== e) begin n_errors++; $display("FAIL up_count: got %h want %h", a_count, e); end
      n_checks++; if (a_cout !== ec) begin n_errors++; $display("FAIL up_cout at %h: got %b want %b", e, a_cout, ec); end
    end
    a_en = 1'b0;
  endtask

  task automatic test_down_wrap();
    int v;
    logic [7:0] e;
    logic       ec;
    load_b(8'h10);
    n_checks++; if (b_count !== 8'h10) begin n_errors++; $display("FAIL down_load: got %h want 10", b_count); end
    v = 10;
    for (int i = 0; i < 11; i++) begin
      if (v == 1) begin v = 12; exp_c_q.push_back(1'b1); end
      else begin v = v - 1; exp_c_q.push_back(1'b0); end
      exp_q.push_back(to_bcd(v));
    end
    b_en = 1'b1; b_up = 1'b0;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      ec = exp_c_q.pop_front();
      n_checks++; if (b_count !== e) begin n_errors++; $display("FAIL down_count: got %h want %h", b_count, e); end
      n_checks++; if (b_cout !== ec) begin n_errors++; $display("FAIL down_cout at %h: got %b want %b", e, b_cout, ec); end
    end
    b_en = 1'b0;
  endtask

  task automatic test_direction_change();
    load_b(8'h05);
    b_en = 1'b1; b_up = 1'b1;
    tick();
    n_checks++; if (b_count !== 8'h06) begin n_errors++; $display("FAIL dir_up: got %h want 06", b_count); end
    b_up = 1'b0;
    tick();
    n_checks++; if (b_count !== 8'h05) begin n_errors++; $display("FAIL dir_down1: got %h want 05", b_count); end
    tick();
    n_checks++; if (b_count !== 8'h04) begin n_errors++; $display("FAIL dir_down2: got %h want 04", b_count); end
    b_en = 1'b0;
  endtask

  task automatic test_load_legality();
    load_a(8'h25);
    load_a(8'h5A);
    n_checks++; if (a_count !== 8'h25) begin n_errors++; $display("FAIL ld_5A_count: got %h want 25", a_count); end
    n_checks++; if (a_load_err !== 1'b1) begin n_errors++; $display("FAIL ld_5A_err: got %b want 1", a_load_err); end
    load_a(8'h60);
    n_checks++; if (a_count !== 8'h25) begin n_errors++; $display("FAIL ld_60_count: got %h want 25", a_count); end
    n_checks++; if (a_load_err !== 1'b1) begin n_errors++; $display("FAIL ld_60_err: got %b want 1", a_load_err); end
    tick();
    n_checks++; if (a_load_err !== 1'b1) begin n_errors++; $display("FAIL ld_err_sticky: got %b want 1", a_load_err); end
    load_a(8'h30);
    n_checks++; if (a_count !== 8'h30) begin n_errors++; $display("FAIL ld_30_count: got %h want 30", a_count); end
    n_checks++; if (a_load_err !== 1'b0) begin n_errors++; $display("FAIL ld_30_err: got %b want 0", a_load_err); end
    load_a(8'h0F);
    n_checks++; if (a_load_err !== 1'b1) begin n_errors++; $display("FAIL ld_0F_err: got %b want 1", a_load_err); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (a_load_err !== 1'b0) begin n_errors++; $display("FAIL ld_rst_err: got %b want 0", a_load_err); end
    #1 rst = 1'b0;
    tick();
    load_b(8'h00);
    n_checks++; if (b_count !== 8'h01) begin n_errors++; $display("FAIL ldb_00_count: got %h want 01", b_count); end
    n_checks++; if (b_load_err !== 1'b1) begin n_errors++; $display("FAIL ldb_00_err: got %b want 1", b_load_err); end
    load_b(8'h13);
    n_checks++; if (b_load_err !== 1'b1) begin n_errors++; $display("FAIL ldb_13_err: got %b want 1", b_load_err); end
    load_b(8'h12);
    n_checks++; if (b_count !== 8'h12) begin n_errors++; $display("FAIL ldb_12_count: got %h want 12", b_count); end
    n_checks++; if (b_load_err !== 1'b0) begin n_errors++; $display("FAIL ldb_12_err: got %b want 0", b_load_err); end
  endtask

  task automatic test_collision();
    load_a(8'h59);
    a_load = 1'b1; a_en = 1'b1; a_up = 1'b1; a_preset = 8'h20;
    tick();
    a_load = 1'b0; a_en = 1'b0;
    n_checks++; if (a_count !== 8'h20) begin n_errors++; $display("FAIL coll_count: got %h want 20", a_count); end
    n_checks++; if (a_cout !== 1'b0) begin n_errors++; $display("FAIL coll_cout: got %b want 0", a_cout); end
  endtask

  task automatic test_hold_pulse();
    load_a(8'h59);
    a_en = 1'b1; a_up = 1'b1;
    tick();
    n_checks++; if (a_count !== 8'h00) begin n_errors++; $display("FAIL hold_wrap_count: got %h want 00", a_count); end
    n_checks++; if (a_cout !== 1'b1) begin n_errors++; $display("FAIL hold_wrap_cout: got %b want 1", a_cout); end
    a_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (a_count !== 8'h00) begin n_errors++; $display("FAIL hold_count[%0d]: got %h want 00", i, a_count); end
      n_checks++; if (a_cout !== 1'b0) begin n_errors++; $display("FAIL hold_cout[%0d]: got %b want 0", i, a_cout); end
    end
    // Wrap pulse cut short by reset.
    load_a(8'h59);
    a_en = 1'b1;
    tick();
    a_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (a_cout !== 1'b0) begin n_errors++; $display("FAIL pulse_trunc: got %b want 0", a_cout); end
    #1 rst = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_async_reset();
    test_up_wrap();
    test_down_wrap();
    test_direction_change();
    test_load_legality();
    test_collision();
    test_hold_pulse();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
